// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and IR field positions
package cpu_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 16;
  localparam int IDX_W = 4;
  localparam int C_W   = 19;

  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
endpackage

// File: rtl/select_encode.sv
// rtl/select_encode.sv - IR field select, one-hot read strobes and C-constant extension
module select_encode
  import cpu_pkg::*;
(
  input  logic [31:0]      IR,
  input  logic             Gra,
  input  logic             Grb,
  input  logic             Grc,
  input  logic             Rout,
  input  logic             BAout,
  output logic [IDX_W-1:0] idx,
  output logic [NREGS-1:0] Rout_onehot,
  output logic [WIDTH-1:0] C_sign_extended,
  output logic             sel_conflict
);
  logic [IDX_W-1:0] w_ra;
  logic [IDX_W-1:0] w_rb;
  logic [IDX_W-1:0] w_rc;
  logic [1:0]       w_sel_cnt;
  logic             w_unused_ir;

  assign w_ra = IR[RA_HI:RA_LO];
  assign w_rb = IR[RB_HI:RB_LO];
  assign w_rc = IR[RC_HI:RC_LO];

  // Multiple selects merge bitwise rather than by priority; sel_conflict flags it.
  assign idx = ({IDX_W{Gra}} & w_ra) | ({IDX_W{Grb}} & w_rb) | ({IDX_W{Grc}} & w_rc);

  assign w_sel_cnt    = {1'b0, Gra} + {1'b0, Grb} + {1'b0, Grc};
  assign sel_conflict = (w_sel_cnt > 2'd1);

  assign Rout_onehot = (Rout | BAout) ? (NREGS'(1) << idx) : '0;

  assign C_sign_extended = {{(WIDTH - C_W){IR[C_W-1]}}, IR[C_W-1:0]};

  assign w_unused_ir = ^IR[31:RA_HI+1];
endmodule

// File: rtl/bus_sink_regfile.sv
// rtl/bus_sink_regfile.sv - general register file fed from BusMuxOut with reservation scoreboard
module bus_sink_regfile
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       BusMuxOut,
  input  logic [31:0]            IR,
  input  logic                   Gra,
  input  logic                   Grb,
  input  logic                   Grc,
  input  logic                   Rin,
  input  logic                   Rout,
  input  logic                   BAout,
  input  logic                   Reserve,
  output logic [NREGS*WIDTH-1:0] BusMuxIn_R,
  output logic [NREGS-1:0]       Rout_onehot,
  output logic [WIDTH-1:0]       C_sign_extended,
  output logic [NREGS-1:0]       busy,
  output logic                   hazard,
  output logic                   sel_conflict
);
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [IDX_W-1:0] w_idx;

  select_encode u_select_encode (
    .IR              (IR),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rout            (Rout),
    .BAout           (BAout),
    .idx             (w_idx),
    .Rout_onehot     (Rout_onehot),
    .C_sign_extended (C_sign_extended),
    .sel_conflict    (sel_conflict)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (Rin) begin
        r_regs[w_idx] <= BusMuxOut;
        r_busy[w_idx] <= 1'b0;
      end
      // A new reservation overrides the release from a same-cycle write-back.
      if (Reserve) begin
        r_busy[w_idx] <= 1'b1;
      end
    end
  end

  // Base-address mode reads R0 as zero without touching the stored value.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      BusMuxIn_R[i*WIDTH +: WIDTH] = r_regs[i];
    end
    if (BAout && (w_idx == '0)) begin
      BusMuxIn_R[0 +: WIDTH] = '0;
    end
  end

  assign busy   = r_busy;
  assign hazard = (Rout | BAout) & r_busy[w_idx];
endmodule

// File: tb/tb_bus_sink_regfile.sv
// tb/tb_bus_sink_regfile.sv - self-checking bench for bus_sink_regfile
module tb_bus_sink_regfile;
  logic         clk = 1'b0;
  logic         clr;
  logic [31:0]  BusMuxOut;
  logic [31:0]  IR;
  logic         Gra, Grb, Grc, Rin, Rout, BAout, Reserve;
  logic [511:0] BusMuxIn_R;
  logic [15:0]  Rout_onehot;
  logic [31:0]  C_sign_extended;
  logic [15:0]  busy;
  logic         hazard;
  logic         sel_conflict;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [16];
  logic [15:0] m_busy;

  bus_sink_regfile dut (
    .clk             (clk),
    .clr             (clr),
    .BusMuxOut       (BusMuxOut),
    .IR              (IR),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .Reserve         (Reserve),
    .BusMuxIn_R      (BusMuxIn_R),
    .Rout_onehot     (Rout_onehot),
    .C_sign_extended (C_sign_extended),
    .busy            (busy),
    .hazard          (hazard),
    .sel_conflict    (sel_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_idx();
    int ix = 0;
    logic [31:0] ir_v = IR;
    if (Gra) ix = ix | int'(ir_v[26:23]);
    if (Grb) ix = ix | int'(ir_v[22:19]);
    if (Grc) ix = ix | int'(ir_v[18:15]);
    return ix;
  endfunction

  function automatic logic [31:0] make_ir(input int ra, input int rb, input int rc);
    logic [31:0] v = 32'h0;
    v[26:23] = 4'(ra);
    v[22:19] = 4'(rb);
    v[18:15] = 4'(rc);
    return v;
  endfunction

  task automatic set_ctl(input logic a, input logic b, input logic c, input logic rin,
                         input logic rout, input logic ba, input logic res);
    Gra = a; Grb = b; Grc = c; Rin = rin; Rout = rout; BAout = ba; Reserve = res;
  endtask

  task automatic check_comb(input string tag);
    int ix;
    int nsel;
    logic signed [18:0] cfield;
    logic [31:0] ir_v;
    #1;
    ix     = model_idx();
    nsel   = int'(Gra) + int'(Grb) + int'(Grc);
    ir_v   = IR;
    cfield = ir_v[18:0];
    check({tag, ".onehot"}, {16'h0, Rout_onehot},
          (Rout || BAout) ? (32'h1 << ix) : 32'h0);
    check({tag, ".conflict"}, {31'h0, sel_conflict}, {31'h0, nsel > 1});
    check({tag, ".hazard"}, {31'h0, hazard}, {31'h0, (Rout || BAout) && m_busy[ix]});
    check({tag, ".csext"}, C_sign_extended, 32'(int'(cfield)));
  endtask

  task automatic check_regs(input string tag);
    int ix;
    logic [31:0] exp;
    ix = model_idx();
    for (int i = 0; i < 16; i++) begin
      exp = m_reg[i];
      if (i == 0 && BAout && ix == 0) exp = 32'h0;
      check($sformatf("%s.R%0d", tag, i), BusMuxIn_R[i*32 +: 32], exp);
    end
    check({tag, ".busy"}, {16'h0, busy}, {16'h0, m_busy});
  endtask

  task automatic clock_edge();
    int ix;
    ix = model_idx();
    if (clr) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
      m_busy = 16'h0;
    end else begin
      if (Rin) begin
        m_reg[ix]  = BusMuxOut;
        m_busy[ix] = 1'b0;
      end
      if (Reserve) m_busy[ix] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = 32'hx;
    m_busy = 16'hx;
    clr = 1'b1; BusMuxOut = 32'hFFFF_FFFF; IR = make_ir(3, 0, 0);
    set_ctl(1, 0, 0, 1, 0, 0, 1);
    @(negedge clk);
    clock_edge();
    clr = 1'b0; set_ctl(0, 0, 0, 0, 0, 0, 0);
    check_regs("reset");

    // write R5 then read it
    IR = make_ir(5, 0, 0); BusMuxOut = 32'hDEAD_BEEF; set_ctl(1, 0, 0, 1, 0, 0, 0);
    clock_edge();
    set_ctl(1, 0, 0, 0, 1, 0, 0);
    check_comb("r5_read");
    check_regs("r5_write");
    check({"r5_onehot"}, {16'h0, Rout_onehot}, 32'h0000_0020);

    // R0 load then BAout versus Rout
    IR = make_ir(0, 0, 0); BusMuxOut = 32'h0000_1234; set_ctl(0, 1, 0, 1, 0, 0, 0);
    clock_edge();
    set_ctl(0, 1, 0, 0, 0, 1, 0);
    check_comb("r0_ba");
    check("r0_ba_zero", BusMuxIn_R[31:0], 32'h0);
    set_ctl(0, 1, 0, 0, 1, 0, 0);
    check_comb("r0_rout");
    check("r0_rout_val", BusMuxIn_R[31:0], 32'h0000_1234);

    // C field sign extension boundaries
    IR = 32'h0004_0000; set_ctl(0, 0, 0, 0, 0, 0, 0);
    check_comb("c_neg");
    check("c_neg_const", C_sign_extended, 32'hFFFC_0000);
    IR = 32'h0003_FFFF;
    check_comb("c_pos");
    check("c_pos_const", C_sign_extended, 32'h0003_FFFF);

    // reservation and release on R7
    IR = make_ir(0, 0, 7); set_ctl(0, 0, 1, 0, 0, 0, 1);
    clock_edge();
    set_ctl(0, 0, 1, 0, 1, 0, 0);
    check_comb("r7_hazard");
    check("r7_hazard_set", {31'h0, hazard}, 32'h1);
    BusMuxOut = 32'hA5A5_0007; set_ctl(0, 0, 1, 1, 1, 0, 0);
    check("r7_old_on_bus", BusMuxIn_R[7*32 +: 32], m_reg[7]);
    clock_edge();
    check_regs("r7_release");
    set_ctl(0, 0, 1, 0, 1, 0, 0);
    check_comb("r7_clear");
    check("r7_hazard_clr", {31'h0, hazard}, 32'h0);

    // select conflict merges indices
    IR = make_ir(4, 2, 0); BusMuxOut = 32'h6666_0006; set_ctl(1, 1, 0, 1, 0, 0, 0);
    check_comb("conflict");
    check("conflict_flag", {31'h0, sel_conflict}, 32'h1);
    clock_edge();
    check_regs("conflict_wr");
    check("conflict_r6", BusMuxIn_R[6*32 +: 32], 32'h6666_0006);

    // Reserve together with Rin keeps the reservation
    IR = make_ir(9, 0, 0); BusMuxOut = 32'h0909_0909; set_ctl(1, 0, 0, 1, 0, 0, 1);
    clock_edge();
    check_regs("res_rin");
    check("res_rin_busy9", {31'h0, busy[9]}, 32'h1);

    // clr mid-operation drops the write and reservations
    BusMuxOut = 32'hBAD0_BAD0; clr = 1'b1; set_ctl(1, 0, 0, 1, 0, 0, 1);
    clock_edge();
    clr = 1'b0; set_ctl(0, 0, 0, 0, 0, 0, 0);
    check_regs("mid_clr");

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      IR        = $urandom;
      BusMuxOut = $urandom;
      clr       = ($urandom_range(0, 31) == 0);
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      check_comb($sformatf("rnd%0d", n));
      clock_edge();
      clr = 1'b0;
      check_regs($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
